// File: rtl/bcd_pkg.sv
// Shared types and elaboration helpers for the shared double-dabble BCD converter.
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        RESP = 2'd2
    } state_t;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < value) r++;
        return r;
    endfunction

    // True when BCD_DIGITS decimal digits can hold the largest BIN_W-bit value.
    function automatic bit digits_ok(input int unsigned bin_w, input int unsigned digits);
        longint unsigned limit;
        limit = 1;
        for (int unsigned i = 0; i < digits; i++) limit = limit * 10;
        return limit > ((64'd1 << bin_w) - 64'd1);
    endfunction

endpackage

// File: rtl/bcd_dd_core.sv
// Iterative double-dabble datapath: one add-3/shift step per enabled cycle.
module bcd_dd_core
    import bcd_pkg::*;
#(
    parameter int BIN_W      = 8,
    parameter int BCD_DIGITS = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load,
    input  logic                    step,
    input  logic [BIN_W-1:0]        bin,
    output logic [4*BCD_DIGITS-1:0] bcd,
    output logic                    last_step
);

    localparam int unsigned CNT_W = clog2(BIN_W);

    logic [BIN_W-1:0]        bin_sr;
    logic [4*BCD_DIGITS-1:0] bcd_sr;
    logic [4*BCD_DIGITS-1:0] adj;
    logic [CNT_W-1:0]        cnt;

    always_comb begin
        adj = '0;
        for (int unsigned i = 0; i < BCD_DIGITS; i++) begin
            if (bcd_sr[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd_sr[4*i +: 4] + 4'd3;
            else                          adj[4*i +: 4] = bcd_sr[4*i +: 4];
        end
    end

    // bcd is the post-step value so the caller can capture the final result on the last edge.
    assign bcd       = (adj << 1) | {{(4*BCD_DIGITS-1){1'b0}}, bin_sr[BIN_W-1]};
    assign last_step = (cnt == CNT_W'(BIN_W - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bin_sr <= '0;
            bcd_sr <= '0;
            cnt    <= '0;
        end else if (load) begin
            bin_sr <= bin;
            bcd_sr <= '0;
            cnt    <= '0;
        end else if (step) begin
            bin_sr <= bin_sr << 1;
            bcd_sr <= bcd;
            cnt    <= last_step ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/bcd_conv_arbiter.sv
// Round-robin arbiter sharing one serial binary-to-BCD engine between N_REQ requesters.
module bcd_conv_arbiter
    import bcd_pkg::*;
#(
    parameter int N_REQ      = 4,
    parameter int BIN_W      = 8,
    parameter int BCD_DIGITS = 3,
    localparam int ID_W      = clog2(N_REQ)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ*BIN_W-1:0]  req_bin,
    output logic [N_REQ-1:0]        req_ready,
    output logic                    resp_valid,
    input  logic                    resp_ready,
    output logic [ID_W-1:0]         resp_id,
    output logic [4*BCD_DIGITS-1:0] resp_bcd,
    output logic                    busy
);

    if (!digits_ok(BIN_W, BCD_DIGITS)) begin : g_digit_check
        $fatal(1, "BCD_DIGITS too small for BIN_W");
    end

    state_t                  state;
    logic [ID_W-1:0]         rr_ptr;
    logic [ID_W-1:0]         cur_id;
    logic [ID_W-1:0]         grant;
    logic                    any_valid;
    logic [BIN_W-1:0]        sel_bin;
    logic [4*BCD_DIGITS-1:0] core_bcd;
    logic                    last_step;
    logic                    accept;

    always_comb begin
        int unsigned idx;
        idx       = 0;
        any_valid = 1'b0;
        grant     = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            idx = (32'(rr_ptr) + k) % N_REQ;
            if (!any_valid && req_valid[idx]) begin
                any_valid = 1'b1;
                grant     = ID_W'(idx);
            end
        end
    end

    assign accept = rst && (state == IDLE) && any_valid;

    always_comb begin
        sel_bin   = '0;
        req_ready = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (grant == ID_W'(i)) begin
                sel_bin      = req_bin[i*BIN_W +: BIN_W];
                req_ready[i] = accept;
            end
        end
    end

    assign busy = (state != IDLE);

    bcd_dd_core #(
        .BIN_W      (BIN_W),
        .BCD_DIGITS (BCD_DIGITS)
    ) u_core (
        .clk       (clk),
        .rst       (rst),
        .load      (accept),
        .step      (state == CONV),
        .bin       (sel_bin),
        .bcd       (core_bcd),
        .last_step (last_step)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            rr_ptr     <= '0;
            cur_id     <= '0;
            resp_valid <= 1'b0;
            resp_id    <= '0;
            resp_bcd   <= '0;
        end else begin
            case (state)
                IDLE: if (any_valid) begin
                    cur_id <= grant;
                    state  <= CONV;
                end
                CONV: if (last_step) begin
                    resp_bcd   <= core_bcd;
                    resp_id    <= cur_id;
                    resp_valid <= 1'b1;
                    state      <= RESP;
                end
                RESP: if (resp_ready) begin
                    resp_valid <= 1'b0;
                    rr_ptr     <= (cur_id == ID_W'(N_REQ - 1)) ? '0 : cur_id + 1'b1;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_conv_arbiter.sv
// Directed and randomized checks of bcd_conv_arbiter against a decimal/round-robin reference model.
module tb_bcd_conv_arbiter;

    localparam int N_REQ      = 4;
    localparam int BIN_W      = 8;
    localparam int BCD_DIGITS = 3;

    logic                    clk = 1'b0;
    logic                    rst;
    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ*BIN_W-1:0]  req_bin;
    logic [N_REQ-1:0]        req_ready;
    logic                    resp_valid;
    logic                    resp_ready;
    logic [1:0]              resp_id;
    logic [4*BCD_DIGITS-1:0] resp_bcd;
    logic                    busy;

    int tests_run = 0;
    int fails     = 0;
    int model_ptr = 0;

    always #5 clk = ~clk;

    bcd_conv_arbiter #(
        .N_REQ      (N_REQ),
        .BIN_W      (BIN_W),
        .BCD_DIGITS (BCD_DIGITS)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_bin    (req_bin),
        .req_ready  (req_ready),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_id    (resp_id),
        .resp_bcd   (resp_bcd),
        .busy       (busy)
    );

    function automatic logic [4*BCD_DIGITS-1:0] to_bcd(input int v);
        logic [4*BCD_DIGITS-1:0] r;
        int x;
        r = '0;
        x = v;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic int model_grant(input logic [N_REQ-1:0] mask);
        for (int k = 0; k < N_REQ; k++)
            if (mask[(model_ptr + k) % N_REQ]) return (model_ptr + k) % N_REQ;
        return 0;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input int v);
        req_bin[i*BIN_W +: BIN_W] = BIN_W'(v);
    endtask

    // One full transaction with the currently driven requests; hold = cycles of RESP backpressure.
    task automatic serve(input int hold);
        int                      id;
        logic [BIN_W-1:0]        op;
        logic [4*BCD_DIGITS-1:0] exp_bcd;
        logic [N_REQ-1:0]        onehot;
        id      = model_grant(req_valid);
        op      = req_bin[id*BIN_W +: BIN_W];
        exp_bcd = to_bcd(int'(op));
        onehot  = '0;
        onehot[id] = 1'b1;
        resp_ready = 1'b0;
        #1;
        check("grant", 32'(req_ready), 32'(onehot));
        check("idle_busy", 32'(busy), 0);
        tick();
        for (int c = 0; c < BIN_W; c++) begin
            check("conv_ready", 32'(req_ready), 0);
            check("conv_busy", 32'(busy), 1);
            check("conv_valid", 32'(resp_valid), 0);
            tick();
        end
        check("resp_valid", 32'(resp_valid), 1);
        check("resp_bcd", 32'(resp_bcd), 32'(exp_bcd));
        check("resp_id", 32'(resp_id), 32'(id));
        for (int h = 0; h < hold; h++) begin
            tick();
            check("hold_valid", 32'(resp_valid), 1);
            check("hold_bcd", 32'(resp_bcd), 32'(exp_bcd));
            check("hold_id", 32'(resp_id), 32'(id));
            check("hold_ready", 32'(req_ready), 0);
            check("hold_busy", 32'(busy), 1);
        end
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        check("done_valid", 32'(resp_valid), 0);
        check("done_busy", 32'(busy), 0);
        model_ptr = (id + 1) % N_REQ;
    endtask

    task automatic do_reset();
        rst        = 1'b0;
        req_valid  = '1;
        resp_ready = 1'b0;
        #1;
        check("rst_ready", 32'(req_ready), 0);
        check("rst_valid", 32'(resp_valid), 0);
        check("rst_bcd", 32'(resp_bcd), 0);
        check("rst_id", 32'(resp_id), 0);
        check("rst_busy", 32'(busy), 0);
        tick();
        req_valid = '0;
        tick();
        rst       = 1'b1;
        model_ptr = 0;
    endtask

    initial begin
        int vals[6];
        rst        = 1'b1;
        req_valid  = '0;
        req_bin    = '0;
        resp_ready = 1'b0;
        #2;
        do_reset();

        // Single max-value request
        req_valid = 4'b0001;
        set_req(0, 255);
        serve(0);
        req_valid = '0;

        // Decimal boundary values on requester 1
        vals = '{0, 9, 10, 99, 100, 128};
        foreach (vals[j]) begin
            req_valid = 4'b0010;
            set_req(1, vals[j]);
            serve(0);
        end
        req_valid = '0;

        // All requesters active from reset: rotation 0,1,2,3,0
        do_reset();
        set_req(0, 11);
        set_req(1, 22);
        set_req(2, 33);
        set_req(3, 44);
        req_valid = '1;
        repeat (5) serve(1);
        req_valid = '0;

        // Backpressure in RESP
        req_valid = 4'b0100;
        set_req(2, 200);
        serve(5);
        req_valid = '0;

        // Reset during the fourth conversion cycle discards the request and the pointer
        req_valid = 4'b0100;
        set_req(2, 77);
        #1;
        check("pre_abort_grant", 32'(req_ready), 32'h4);
        tick();
        repeat (3) tick();
        rst = 1'b0;
        #1;
        check("abort_valid", 32'(resp_valid), 0);
        check("abort_busy", 32'(busy), 0);
        check("abort_ready", 32'(req_ready), 0);
        req_valid = 4'b1010;
        set_req(1, 42);
        set_req(3, 99);
        tick();
        rst       = 1'b1;
        model_ptr = 0;
        check("post_abort_valid", 32'(resp_valid), 0);
        serve(0);
        req_valid = '0;

        // Full operand sweep on requester 2 with random backpressure
        req_valid = 4'b0100;
        for (int v = 0; v < 256; v++) begin
            set_req(2, v);
            serve(int'($urandom_range(0, 2)));
        end
        req_valid = '0;

        // Random request masks and operands
        for (int n = 0; n < 40; n++) begin
            for (int i = 0; i < N_REQ; i++) set_req(i, int'($urandom_range(0, 255)));
            req_valid = N_REQ'($urandom_range(1, 15));
            serve(int'($urandom_range(0, 3)));
        end
        req_valid = '0;

        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule

// File: doc/bcd_conv_arbiter.md
Name: bcd_conv_arbiter

Overview:
- Shares one serial double-dabble binary-to-BCD engine between N_REQ requesters.
- Round-robin arbitration with a valid/ready request per requester and one valid/ready response channel tagged with the requester ID.
- Sits between producers of binary values (counters, sensor readouts) and display/formatting logic that consumes packed BCD digits.

Parameters:
- N_REQ, 4: number of requesters (2..8).
- BIN_W, 8: binary operand width (4..16).
- BCD_DIGITS, 3: output digits; must satisfy 10^BCD_DIGITS > 2^BIN_W - 1. Checked by elaboration-time assertion.
- ID_W (localparam), clog2(N_REQ): response ID width.

Ports:
- clk, input, 1: single clock; all state on rising edge.
- rst, input, 1: asynchronous, active-low reset (0 = reset asserted).
- req_valid, input, N_REQ: per-requester request valid.
- req_bin, input, N_REQ*BIN_W: operands; requester i occupies bits [i*BIN_W +: BIN_W].
- req_ready, output, N_REQ: one-hot grant/accept; at most one bit high.
- resp_valid, output, 1: result available.
- resp_ready, input, 1: consumer accepts result.
- resp_id, output, ID_W: index of the requester whose value is in resp_bcd.
- resp_bcd, output, 4*BCD_DIGITS: packed BCD, digit 0 in [3:0].
- busy, output, 1: high in any state other than IDLE.

Behaviour:
- FSM states: IDLE, CONV, RESP.
- Reset (rst=0, asynchronous):
  - state=IDLE, rr_ptr=0, step counter=0, shift register=0.
  - resp_valid=0, resp_id=0, resp_bcd=0, busy=0.
  - req_ready is forced 0 while rst=0.
- IDLE:
  - Grant = first i with req_valid[i]=1, searching rr_ptr, rr_ptr+1, ... modulo N_REQ.
  - req_ready[grant] is asserted combinationally in the same cycle; the transfer happens on that edge.
  - On the edge: capture req_bin[grant] and grant ID, clear the BCD register, go to CONV.
  - No valid requests: stay in IDLE, req_ready all 0.
- CONV: exactly BIN_W cycles. Each cycle:
  - In every BCD digit, add 3 to any digit >= 5.
  - Then shift {bcd, bin} left by one bit; the bin MSB enters bcd bit 0.
  - The step counter counts 0..BIN_W-1. On the last step, load resp_bcd and resp_id, set resp_valid=1, go to RESP.
  - req_ready is 0 in CONV and RESP.
- RESP:
  - Hold resp_valid, resp_bcd and resp_id stable until resp_valid && resp_ready.
  - On that edge: resp_valid=0, rr_ptr=(grant+1) mod N_REQ, go to IDLE.
- Timing:
  - Latency: request accepted at edge T -> resp_valid high after edge T+BIN_W.
  - Minimum spacing between accepts is BIN_W+2 cycles.
- Requester rules:
  - A requester may drop req_valid before being granted; this is legal and not an error.
  - req_bin is sampled only at the accept edge.
- Wrap-around: rr_ptr wraps from N_REQ-1 to 0. When N_REQ is not a power of 2, ID values >= N_REQ are never produced.
- Simultaneous events: a new request arriving in RESP while resp_ready=1 is not accepted until the following IDLE cycle (no bypass).
- Reset mid-operation: the conversion in flight is discarded, no response is emitted, and rr_ptr returns to 0.
- Arithmetic: the add-3 is 4-bit and cannot overflow, because a digit <= 9 before adjust is <= 12 after it. The BCD register is exactly 4*BCD_DIGITS wide; no carry leaves it when the BCD_DIGITS constraint holds.

Decomposition:
- Package bcd_pkg:
  - FSM state enum (IDLE/CONV/RESP).
  - clog2 function.
  - Digit-count check function used by the elaboration assertion.
- Sub-module bcd_dd_core: iterative double-dabble datapath.
  - Inputs: load, bin, step.
  - Outputs: bcd, last_step.
- The top level holds the arbiter, the FSM and the response registers.

Test Plan:
1. Reset, then req_valid[0]=1 with req_bin[0]=255 -> req_ready[0] high in the same cycle. resp_valid rises 8 edges after accept with resp_bcd=12'h255, resp_id=0; busy high throughout.
2. Boundary values 0, 9, 10, 99, 100, 128 on requester 1 -> resp_bcd = 000, 009, 010, 099, 100, 128.
3. All four req_valid held high with distinct values from reset -> grants in order 0,1,2,3,0. Each response carries the matching ID and value; no two req_ready bits are ever high together.
4. Backpressure: hold resp_ready=0 for 5 cycles in RESP -> resp_valid, resp_bcd and resp_id stay stable and req_ready stays 0. Release -> IDLE on the next edge.
5. Drive rst=0 during the 4th CONV cycle -> resp_valid=0 immediately and no response is produced. After release, a request with 42 yields 12'h042 with ID from pointer 0.
6. Sweep 0..255 through requester 2 with random resp_ready -> every resp_bcd matches the decimal digits of its operand.
